gpio_mmio_bank: RTL and testbench

Parametrised memory-mapped GPIO bank. It replaces the single-register output-only GPIO port with a bank of up to 32 pins that adds:
- per-pin output enable,
- synchronised pin input,
- atomic set/clear/toggle of the output register,
- sticky rising-edge interrupt status with a level interrupt output.

It sits on the CPU data-memory bus alongside RAM, decodes its own 32-byte window, and returns read data as a combinational mux for the SoC read-data OR-tree.

---
 rtl/gpio_mmio_bank.sv | 76 +++++++
 tb/tb_gpio_mmio_bank.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_mmio_bank.sv
`timescale 1ns/1ps
// gpio_mmio_bank: memory-mapped GPIO bank with output enable, synchronised input and sticky rising-edge interrupts
module gpio_mmio_bank #(
   parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
   parameter int          WIDTH       = 32,
   parameter int          SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [31:0]      mem_addr,
   input  logic [31:0]      mem_wdata,
   input  logic [3:0]       mem_wmask,
   output logic [31:0]      gpio_rdata,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq
);
   localparam logic [63:0] ONES       = (64'd1 << WIDTH) - 64'd1;
   localparam logic [31:0] PIN_MASK   = ONES[31:0];
   localparam logic [2:0]  ARM_CYCLES = 3'(SYNC_STAGES + 1);
   logic [31:0]      out_q, oe_q, ien_q, stat_q, prev_q;
   logic [31:0]      out_d, oe_d, ien_d, w1c, in_w, rise, byte_mask, wd;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [2:0]       arm_q;
   logic [2:0]       off;
   logic             sel, wr;
   logic             unused_ok;
   assign sel       = mem_addr[31:5] == BASE_ADDR[31:5];
   assign wr        = sel && |mem_wmask;
   assign off       = mem_addr[4:2];
   assign unused_ok = ^mem_addr[1:0];
   assign byte_mask = {{8{mem_wmask[3]}}, {8{mem_wmask[2]}}, {8{mem_wmask[1]}}, {8{mem_wmask[0]}}};
   assign wd        = mem_wdata & byte_mask & PIN_MASK;
   assign in_w      = 32'(sync_q[SYNC_STAGES-1]);
   // pins already high when reset releases must not look like edges, so rise waits for the chain to fill
   assign rise      = (arm_q == ARM_CYCLES) ? in_w & ~prev_q : '0;
   assign out_d = !wr          ? out_q :
                  off == 3'd0  ? (out_q & ~byte_mask) | wd :
                  off == 3'd3  ? out_q | wd :
                  off == 3'd4  ? out_q & ~wd :
                  off == 3'd5  ? out_q ^ wd : out_q;
   assign oe_d  = (wr && off == 3'd1) ? (oe_q & ~byte_mask) | wd : oe_q;
   assign ien_d = (wr && off == 3'd6) ? (ien_q & ~byte_mask) | wd : ien_q;
   assign w1c   = (wr && off == 3'd7) ? wd : '0;
   assign gpio_rdata = !sel        ? '0 :
                       off == 3'd0 ? out_q :
                       off == 3'd1 ? oe_q :
                       off == 3'd2 ? in_w :
                       off == 3'd6 ? ien_q :
                       off == 3'd7 ? stat_q : '0;
   assign gpio_out = out_q[WIDTH-1:0];
   assign gpio_oe  = oe_q[WIDTH-1:0];
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_q  <= '0;
         oe_q   <= '0;
         ien_q  <= '0;
         stat_q <= '0;
         prev_q <= '0;
         arm_q  <= '0;
         irq    <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         out_q  <= out_d;
         oe_q   <= oe_d;
         ien_q  <= ien_d;
         stat_q <= (stat_q & ~w1c) | rise;
         prev_q <= in_w;
         arm_q  <= (arm_q == ARM_CYCLES) ? arm_q : arm_q + 3'd1;
         irq    <= |(stat_q & ien_q);
         sync_q[0] <= gpio_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end
endmodule

// File: tb/tb_gpio_mmio_bank.sv
`timescale 1ns/1ps
// tb_gpio_mmio_bank: directed and random checks of the GPIO bank against a pin-history reference model
module tb_gpio_mmio_bank;
   localparam logic [31:0] BASE  = 32'h2000_0000;
   localparam logic [31:0] BASE8 = 32'h2000_0100;
   localparam int          S     = 2;
   logic        clk = 1'b0, resetn = 1'b1;
   logic [31:0] mem_addr = '0, mem_wdata = '0, pins = '0;
   logic [3:0]  mem_wmask = '0;
   logic [31:0] rdata, out, oe, rdata8;
   logic [7:0]  out8, oe8;
   logic        irq, irq8;
   int          checks = 0, errors = 0;
   logic [31:0] m_out, m_oe, m_ien, m_stat;
   logic        m_irq;
   logic [31:0] hist[$];
   int          ncyc;
   always #5 clk = ~clk;
   gpio_mmio_bank #(.BASE_ADDR(BASE), .WIDTH(32), .SYNC_STAGES(S)) dut (
      .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .gpio_rdata(rdata), .gpio_in(pins), .gpio_out(out), .gpio_oe(oe), .irq(irq));
   gpio_mmio_bank #(.BASE_ADDR(BASE8), .WIDTH(8), .SYNC_STAGES(S)) dut8 (
      .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .gpio_rdata(rdata8), .gpio_in(8'h00), .gpio_out(out8), .gpio_oe(oe8), .irq(irq8));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] in_now();
      return (hist.size() >= S) ? hist[S-1] : 32'h0;
   endfunction
   function automatic logic [31:0] prev_now();
      return (hist.size() > S) ? hist[S] : 32'h0;
   endfunction
   function automatic logic [31:0] m_read(input logic [31:0] a);
      logic [2:0] o;
      o = a[4:2];
      if ((a >> 5) != (BASE >> 5)) return 32'h0;
      case (o)
         3'd0: return m_out;
         3'd1: return m_oe;
         3'd2: return in_now();
         3'd6: return m_ien;
         3'd7: return m_stat;
         default: return 32'h0;
      endcase
   endfunction
   task automatic model_reset();
      m_out = '0; m_oe = '0; m_ien = '0; m_stat = '0; m_irq = 1'b0;
      hist.delete();
      ncyc = 0;
   endtask
   task automatic model_edge(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
      logic [31:0] bm, d, rise, w1c;
      logic [2:0]  o;
      o    = a[4:2];
      bm   = {{8{wm[3]}}, {8{wm[2]}}, {8{wm[1]}}, {8{wm[0]}}};
      d    = wd & bm;
      w1c  = '0;
      rise = (ncyc >= S + 1) ? in_now() & ~prev_now() : 32'h0;
      m_irq = |(m_stat & m_ien);
      if ((a >> 5) == (BASE >> 5) && wm != 4'h0)
         case (o)
            3'd0: m_out = (m_out & ~bm) | d;
            3'd1: m_oe  = (m_oe & ~bm) | d;
            3'd3: m_out = m_out | d;
            3'd4: m_out = m_out & ~d;
            3'd5: m_out = m_out ^ d;
            3'd6: m_ien = (m_ien & ~bm) | d;
            3'd7: w1c   = d;
            default: ;
         endcase
      m_stat = (m_stat & ~w1c) | rise;
      hist.push_front(pins);
      if (hist.size() > S + 1) void'(hist.pop_back());
      ncyc++;
   endtask
   task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
      mem_addr = a; mem_wdata = wd; mem_wmask = wm;
      #1;
      chk("rdata", rdata, m_read(a));
      @(posedge clk);
      model_edge(a, wd, wm);
      #1;
      chk("gpio_out", out, m_out);
      chk("gpio_oe", oe, m_oe);
      chk("irq", {31'b0, irq}, {31'b0, m_irq});
   endtask
   task automatic idle();
      step(BASE + 32'h08, 32'h0, 4'h0);
   endtask
   task automatic peek(input logic [31:0] a, input string tag);
      mem_addr = a; mem_wmask = 4'h0;
      #1;
      chk(tag, rdata, m_read(a));
   endtask
   task automatic do_reset();
      #2 resetn = 1'b0;
      mem_wmask = 4'h0;
      #1;
      chk("rst_out", out, 32'h0);
      chk("rst_oe", oe, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      chk("rst_out8", {24'h0, out8}, 32'h0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
   endtask
   task automatic rand_steps(input int n);
      logic [31:0] a;
      for (int k = 0; k < n; k++) begin
         if ($urandom_range(0, 2) == 0) pins = pins ^ ($urandom & $urandom & $urandom);
         a = ($urandom_range(0, 9) == 0) ? $urandom
             : BASE | 32'($urandom_range(0, 7) * 4) | 32'($urandom_range(0, 3));
         step(a, $urandom, ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom));
      end
   endtask
   initial begin
      model_reset();
      do_reset();
      peek(BASE + 32'h1C, "rst_stat_rd");
      chk("rst_stat", rdata, 32'h0);
      step(BASE, 32'hA5A5_A5A5, 4'b0011);
      chk("out_bytemask", out, 32'h0000_A5A5);
      peek(BASE, "out_rd_model");
      chk("out_rd", rdata, 32'h0000_A5A5);
      peek(32'h2000_0020, "oow_model");
      chk("oow", rdata, 32'h0);
      step(BASE, 32'h0000_00F0, 4'hF);
      step(BASE + 32'h0C, 32'h0F, 4'hF);
      chk("set", out, 32'hFF);
      step(BASE + 32'h10, 32'h3C, 4'hF);
      chk("clr", out, 32'hC3);
      step(BASE + 32'h14, 32'hFF, 4'hF);
      chk("tgl", out, 32'h3C);
      for (int k = 3; k <= 5; k++) begin
         peek(BASE + 32'(k * 4), "wo_model");
         chk("wo_rd0", rdata, 32'h0);
      end
      step(BASE + 32'h08, 32'hFFFF_FFFF, 4'hF);
      peek(BASE + 32'h08, "in_ro_model");
      chk("in_ro", rdata, 32'h0);
      step(BASE + 32'h18, 32'h8, 4'hF);
      pins = 32'h8;
      idle();
      peek(BASE + 32'h08, "in_e1_model");
      chk("in_e1", rdata, 32'h0);
      idle();
      peek(BASE + 32'h08, "in_e2_model");
      chk("in_e2", rdata, 32'h8);
      peek(BASE + 32'h1C, "stat_e2_model");
      chk("stat_e2", rdata, 32'h0);
      idle();
      peek(BASE + 32'h1C, "stat_e3_model");
      chk("stat_e3", rdata, 32'h8);
      chk("irq_e3", {31'b0, irq}, 32'h0);
      idle();
      chk("irq_e4", {31'b0, irq}, 32'h1);
      pins = 32'h0;
      repeat (3) idle();
      step(BASE + 32'h1C, 32'h8, 4'hF);
      chk("irq_after_w1c", {31'b0, irq}, 32'h1);
      idle();
      chk("irq_dropped", {31'b0, irq}, 32'h0);
      pins = 32'h8;
      idle();
      idle();
      step(BASE + 32'h1C, 32'h8, 4'hF);
      peek(BASE + 32'h1C, "stat_setwins_model");
      chk("stat_setwins", rdata, 32'h8);
      idle();
      step(BASE + 32'h1C, 32'h8, 4'hF);
      peek(BASE + 32'h1C, "stat_w1c_model");
      chk("stat_w1c", rdata, 32'h0);
      chk("irq_w1c_hold", {31'b0, irq}, 32'h1);
      idle();
      chk("irq_w1c_drop", {31'b0, irq}, 32'h0);
      pins = 32'hFFFF_FFFF;
      do_reset();
      repeat (8) idle();
      peek(BASE + 32'h1C, "arm_model");
      chk("arm_masked", rdata, 32'h0);
      pins = 32'h0;
      repeat (4) idle();
      pins = 32'hFFFF_FFFF;
      repeat (4) idle();
      peek(BASE + 32'h1C, "rearm_model");
      chk("rearm_rise", rdata, 32'hFFFF_FFFF);
      step(BASE8, 32'hFFFF_FFFF, 4'hF);
      chk("w8_out", {24'h0, out8}, 32'hFF);
      mem_addr = BASE8;
      #1;
      chk("w8_rd", rdata8, 32'hFF);
      step(BASE, 32'h1234_5678, 4'hF);
      step(BASE + 32'h04, 32'hFFFF, 4'hF);
      do_reset();
      rand_steps(600);
      do_reset();
      rand_steps(200);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
